// File: rtl/controlador_fetch_if.sv
// ROM read bus and debug/loader read port shared by the fetch controller.
// slave = fetch controller side, master = ROM plus debug requester side.
interface controlador_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_instr;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_rvalid;

  modport slave (
    output mem_addr,
    input  mem_instr,
    input  dbg_req,
    input  dbg_addr,
    output dbg_gnt,
    output dbg_data,
    output dbg_rvalid
  );

  modport master (
    input  mem_addr,
    output mem_instr,
    output dbg_req,
    output dbg_addr,
    input  dbg_gnt,
    input  dbg_data,
    input  dbg_rvalid
  );
endinterface

// File: rtl/controlador_fetch.sv
// Fetch controller: owns the PC, loads IF/ID, handles stall/redirect/HLT; ROM port shared with a debug reader.
// The debug reader and its bounded-wait slot stealing exist only when DBG_PORT_EN is defined.
module controlador_fetch #(
  parameter int                 ADDR_W       = 10,
  parameter int                 DATA_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD    = '0,
  parameter int                 DBG_MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  controlador_fetch_if.slave  bus,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic [DATA_W-1:0]   if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic                if_valid,
  output logic                halted
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic                if_valid_q, if_valid_d;
  logic                halted_q, halted_d;
  logic                dbg_gnt;

`ifdef DBG_PORT_EN
  localparam int WAIT_W = $clog2(DBG_MAX_WAIT + 1);

  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;

  // The cycle after a grant carries rvalid; the requester is retiring, so no grant then.
  always_comb begin
    dbg_gnt = 1'b0;
    if (bus.dbg_req && !dbg_rvalid_q) begin
      case (state_q)
        ST_RUN:  dbg_gnt = !redirect_valid &&
                           (stall || (wait_cnt_q == WAIT_W'(DBG_MAX_WAIT)));
        ST_HALT: dbg_gnt = 1'b1;
        default: dbg_gnt = 1'b0;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    dbg_rvalid_d = dbg_gnt;
    dbg_data_d   = dbg_gnt ? bus.mem_instr : dbg_data_q;
    if (dbg_gnt || !bus.dbg_req) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_RUN && wait_cnt_q != WAIT_W'(DBG_MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      dbg_data_q   <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      dbg_data_q   <= dbg_data_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign bus.mem_addr   = dbg_gnt ? bus.dbg_addr : pc_q;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_data   = dbg_data_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
`else
  logic unused_dbg;

  assign dbg_gnt        = 1'b0;
  assign unused_dbg     = ^{bus.dbg_req, bus.dbg_addr};
  assign bus.mem_addr   = pc_q;
  assign bus.dbg_gnt    = 1'b0;
  assign bus.dbg_data   = '0;
  assign bus.dbg_rvalid = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if (dbg_gnt) begin
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = bus.mem_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            // HLT still enters IF/ID so it drains down the pipe; the PC parks on it.
            if (bus.mem_instr == HALT_WORD) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
      end
      ST_HALT: begin
        if (!stall) if_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d     = redirect_target;
          halted_d = 1'b0;
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_controlador_fetch.sv
// Bench for controlador_fetch: directed scenarios plus random stall/redirect/debug traffic against a reference model.
module tb_controlador_fetch;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_valid;
  logic          halted;
  logic [DW-1:0] rom [1024];

  always #5 clk = ~clk;

  controlador_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.mem_instr = rom[bus.mem_addr];
  assign bus.dbg_req   = dbg_req;
  assign bus.dbg_addr  = dbg_addr;

  controlador_fetch #(.ADDR_W(AW), .DATA_W(DW), .DBG_MAX_WAIT(MAXW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .halted          (halted)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode, m_pc, m_iv, m_ipc, m_halt, m_rv, m_wait, m_gnt, m_addr;
  logic [31:0] m_iin, m_dd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_iv = 0; m_ipc = 0; m_iin = '0;
    m_halt = 0; m_dd = '0; m_rv = 0; m_wait = 0;
  endtask

  task automatic model_comb();
    m_gnt = 0;
`ifdef DBG_PORT_EN
    if (dbg_req && m_rv == 0) begin
      if (m_mode == 1) m_gnt = (!redirect_valid && (stall || m_wait >= MAXW)) ? 1 : 0;
      else if (m_mode == 2) m_gnt = 1;
    end
`endif
    m_addr = (m_gnt != 0) ? int'(dbg_addr) : m_pc;
  endtask

  task automatic model_step();
    logic [31:0] w;
    w = rom[m_addr];
`ifdef DBG_PORT_EN
    if (m_gnt != 0 || !dbg_req) m_wait = 0;
    else if (m_mode == 1 && m_wait < MAXW) m_wait++;
`endif
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        m_pc = int'(redirect_target); m_iv = 0;
      end else if (!stall) begin
        if (m_gnt != 0) m_iv = 0;
        else begin
          m_iin = w; m_ipc = m_pc; m_iv = 1;
          if (w == 32'h0) begin m_mode = 2; m_halt = 1; end
          else m_pc = (m_pc + 1) % 1024;
        end
      end
    end else begin
      if (!stall) m_iv = 0;
      if (redirect_valid) begin m_pc = int'(redirect_target); m_halt = 0; m_mode = 1; end
    end
    m_rv = m_gnt;
    if (m_gnt != 0) m_dd = w;
  endtask

  // One clock: comb outputs checked at negedge, registered outputs #1 after posedge.
  task automatic step();
    @(negedge clk);
    model_comb();
    check("dbg_gnt", 64'(bus.dbg_gnt), 64'(m_gnt));
    check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
    model_step();
    @(posedge clk);
    #1;
    check("if_valid", 64'(if_valid), 64'(m_iv));
    check("if_pc", 64'(if_pc), 64'(m_ipc));
    check("if_instr", 64'(if_instr), 64'(m_iin));
    check("halted", 64'(halted), 64'(m_halt));
    check("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(m_rv));
    check("dbg_data", 64'(bus.dbg_data), 64'(m_dd));
  endtask

  task automatic random_inputs();
    stall           = ($urandom_range(0, 4) == 0);
    redirect_valid  = ($urandom_range(0, 9) == 0);
    redirect_target = ($urandom_range(0, 3) == 0) ? AW'(1020 + $urandom_range(0, 3)) : AW'($urandom);
    if (m_rv != 0) dbg_req = 1'b0;
    else if (!dbg_req && $urandom_range(0, 5) == 0) begin
      dbg_req  = 1'b1;
      dbg_addr = AW'($urandom);
    end
  endtask

  initial begin
    int n, bub;
    logic got;
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
    for (int i = 0; i < 11; i++) rom[i] = 32'h0000_0033 | (32'(i) << 7);
    rom[4] = 32'h0;
    for (int i = 32'h0F0; i < 32'h120; i++) rom[i] = 32'h0040_0033 + 32'(i);
    for (int i = 32'h1F0; i < 32'h220; i++) rom[i] = 32'h0080_0033 + 32'(i);
    for (int i = 1016; i < 1024; i++) rom[i] = 32'h00C0_0033 + 32'(i);

    model_reset();
    #12;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(); check("boot_bubble", 64'(if_valid), 64'd0);
    step(); check("seq_pc0", 64'(if_pc), 64'd0); check("seq_v0", 64'(if_valid), 64'd1);
    step(); check("seq_pc1", 64'(if_pc), 64'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_pc", 64'(if_pc), 64'd1); check("stall_instr", 64'(if_instr), 64'(rom[1]));
    end
    stall = 1'b0;
    step(); check("resume_pc2", 64'(if_pc), 64'd2);
    step(); check("seq_pc3", 64'(if_pc), 64'd3);
    step(); check("hlt_pc4", 64'(if_pc), 64'd4); check("hlt_v", 64'(if_valid), 64'd1);
    check("hlt_halted", 64'(halted), 64'd1);
    step(); check("halt_bubble", 64'(if_valid), 64'd0);
    step(); check("halt_bubble2", 64'(if_valid), 64'd0);
    redirect_valid = 1'b1; redirect_target = AW'(8);
    step(); check("unhalt", 64'(halted), 64'd0);
    redirect_valid = 1'b0;
    step(); check("redir_pc8", 64'(if_pc), 64'd8); check("redir_v8", 64'(if_valid), 64'd1);
    redirect_valid = 1'b1; redirect_target = AW'(10'h200); stall = 1'b1;
    step(); check("flush", 64'(if_valid), 64'd0);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check("redir_200", 64'(if_pc), 64'h200);
    redirect_valid = 1'b1; redirect_target = AW'(1023);
    step();
    redirect_valid = 1'b0;
    step(); check("wrap_1023", 64'(if_pc), 64'd1023);
    step(); check("wrap_0", 64'(if_pc), 64'd0);
    redirect_valid = 1'b1; redirect_target = AW'(10'h100);
    step();
    redirect_valid = 1'b0;

`ifdef DBG_PORT_EN
    dbg_req = 1'b1; dbg_addr = AW'(3);
    n = 0; bub = 0; got = 1'b0;
    while (n < 20 && !got) begin
      step();
      n++;
      if (!if_valid) bub++;
      if (bus.dbg_rvalid) got = 1'b1;
    end
    check("dbg_latency", 64'(n), 64'd9);
    check("dbg_bubbles", 64'(bub), 64'd1);
    check("dbg_rom3", 64'(bus.dbg_data), 64'(rom[3]));
    dbg_req = 1'b0;
    step();
`endif

    for (int c = 0; c < 3000; c++) begin
      random_inputs();
      step();
    end

    // Reset arriving while a debug read is granted must not produce rvalid.
    stall = 1'b1; redirect_valid = 1'b0; dbg_req = 1'b0;
    step();
    dbg_req = 1'b1; dbg_addr = AW'(5);
    @(negedge clk); #1;
    model_comb();
    check("rst_mid_gnt", 64'(bus.dbg_gnt), 64'(m_gnt));
    rst_n = 1'b0;
    #1;
    check("rst_async_v", 64'(if_valid), 64'd0);
    @(posedge clk); #1;
    check("rst_mid_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    check("rst_mid_v", 64'(if_valid), 64'd0);
    model_reset();
    dbg_req = 1'b0; stall = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      random_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
